// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: reads one byte per frame from the FIFO and sends it as 8N1 (8E1 with UART_TX_PARITY_EN) on txd.
// Latency: start bit 2 cycles after fifo_rd; reads pace at 10N+3 (11N+3) cycles; en gates only new frames.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        txd,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
`endif

  logic [2:0]    state, nxt_state;
  logic [CW-1:0] baud_cnt, nxt_cnt;
  logic [2:0]    bit_idx, nxt_bit;
  logic [7:0]    shift, nxt_shift;
  logic          nxt_txd;
  logic          cnt_last;
  logic          timed;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign cnt_last = (baud_cnt == CNT_LAST);
  assign fifo_rd  = (state == RD);
  assign busy     = (state != IDLE);
  assign tx_done  = (state == STOP) && cnt_last;

  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_idx;
    nxt_shift = shift;
    timed     = 1'b0;
    case (state)
      IDLE:  if (en && !fifo_empty) nxt_state = RD;
      RD:    nxt_state = WAIT;
      WAIT: begin
        nxt_state = START;
        nxt_shift = fifo_data;
      end
      START: begin
        timed = 1'b1;
        if (cnt_last) nxt_state = DATA;
      end
      DATA: begin
        timed = 1'b1;
        if (cnt_last) begin
          nxt_shift = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            nxt_bit = 3'd0;
`ifdef UART_TX_PARITY_EN
            nxt_state = PARITY;
`else
            nxt_state = STOP;
`endif
          end else begin
            nxt_bit = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        timed = 1'b1;
        if (cnt_last) nxt_state = STOP;
      end
`endif
      STOP: begin
        timed = 1'b1;
        if (cnt_last) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    // The counter restarts on any state change and at every bit boundary inside DATA.
    nxt_cnt = '0;
    if (timed && (nxt_state == state) && !cnt_last) nxt_cnt = baud_cnt + CW'(1);

    // txd is computed from the next state so the registered line lines up with the state.
    nxt_txd = 1'b1;
    case (nxt_state)
      START:  nxt_txd = 1'b0;
      DATA:   nxt_txd = nxt_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: nxt_txd = parity_bit;
`endif
      default: nxt_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      txd         <= 1'b1;
      frames_sent <= 16'h0000;
    end else begin
      state    <= nxt_state;
      baud_cnt <= nxt_cnt;
      bit_idx  <= nxt_bit;
      shift    <= nxt_shift;
      txd      <= nxt_txd;
      if (tx_done) frames_sent <= frames_sent + 16'd1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken at load time since the shift register is consumed by DATA.
  always_ff @(posedge clk or negedge res) begin
    if (!res) parity_bit <= 1'b0;
    else if (state == WAIT) parity_bit <= ^fifo_data;
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with N=4: FIFO model plus a line scoreboard that decodes every frame on txd.
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
module tb_fifo_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd;
  logic        txd;
  logic        busy;
  logic        tx_done;
  logic [15:0] frames_sent;

  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  bit         bad_rd = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         exp_frames = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .res(res), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .txd(txd), .busy(busy), .tx_done(tx_done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (fifo_q.size() == 0) bad_rd <= 1'b1;
      else fifo_data <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    sb_q.push_back(b);
  endtask

  task automatic run_cycles(input int n, output int rd_cnt, output int done_cnt, output int busy_cnt);
    rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) rd_cnt++;
      if (tx_done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  // Scoreboard consumer: every start bit pops the next expected byte and checks the whole frame.
  task automatic monitor();
    logic [7:0]    b;
    logic [FB-1:0] bits;
    bit            ok;
    forever begin
      @(negedge clk);
      if (res === 1'b1 && txd === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: start bit seen, scoreboard empty");
        end else begin
          b = sb_q.pop_front();
          bits = '1;
          bits[0] = 1'b0;
          bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
          bits[9] = ^b;
`endif
          ok = 1'b1;
          for (int k = 0; k < FB * N && ok; k++) begin
            if (k > 0) @(negedge clk);
            if (res !== 1'b1) begin
              ok = 1'b0;
            end else begin
              checks++;
              if (txd !== bits[k / N]) begin
                errors++; ok = 1'b0;
                $display("FAIL txd_bit byte=%h bit=%0d cyc=%0d got %b exp %b", b, k / N, k % N, txd, bits[k / N]);
              end
              checks++;
              if (tx_done !== (k == FB * N - 1)) begin
                errors++; ok = 1'b0;
                $display("FAIL tx_done byte=%h cyc=%0d got %b exp %b", b, k, tx_done, (k == FB * N - 1));
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got %b exp 0", fifo_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b exp 0", tx_done); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL reset_frames got %h exp 0000", frames_sent); end
    res = 1'b1;
    exp_frames = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    int rd, dn, bz;
    push_byte(b);
    repeat (2) @(negedge clk);
    en = 1'b1;
    run_cycles(60, rd, dn, bz);
    en = 1'b0;
    exp_frames++;
    checks++; if (rd != 1) begin errors++; $display("FAIL %s_rd_pulses got %0d exp 1", name, rd); end
    checks++; if (dn != 1) begin errors++; $display("FAIL %s_done_pulses got %0d exp 1", name, dn); end
    checks++; if (bz != FB * N + 2) begin errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", name, bz, FB * N + 2); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL %s_frames got %0d exp %0d", name, frames_sent, exp_frames); end
  endtask

  task automatic test_back_to_back();
    logic txd_h[160];
    logic busy_h[160];
    int   rd_idx[2];
    int   rd = 0, dn = 0;
    push_byte(8'h3C);
    push_byte(8'hFF);
    repeat (2) @(negedge clk);
    en = 1'b1;
    rd_idx[0] = -1; rd_idx[1] = -1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      txd_h[i] = txd;
      busy_h[i] = busy;
      if (fifo_rd === 1'b1) begin
        if (rd < 2) rd_idx[rd] = i;
        rd++;
      end
      if (tx_done === 1'b1) dn++;
    end
    en = 1'b0;
    exp_frames += 2;
    checks++; if (rd != 2) begin errors++; $display("FAIL b2b_rd_pulses got %0d exp 2", rd); end
    checks++; if (dn != 2) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 2", dn); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frames got %0d exp %0d", frames_sent, exp_frames); end
    if (rd == 2 && rd_idx[1] >= 2 && rd_idx[1] + 2 < 160) begin
      checks++;
      if (rd_idx[1] - rd_idx[0] != FB * N + 3) begin
        errors++; $display("FAIL b2b_rd_spacing got %0d exp %0d", rd_idx[1] - rd_idx[0], FB * N + 3);
      end
      checks++;
      if ({txd_h[rd_idx[1] - 2], txd_h[rd_idx[1] - 1], txd_h[rd_idx[1]], txd_h[rd_idx[1] + 1], txd_h[rd_idx[1] + 2]} !== 5'b11110) begin
        errors++; $display("FAIL b2b_gap_txd got %b%b%b%b%b exp 11110", txd_h[rd_idx[1] - 2], txd_h[rd_idx[1] - 1],
                           txd_h[rd_idx[1]], txd_h[rd_idx[1] + 1], txd_h[rd_idx[1] + 2]);
      end
      checks++;
      if (busy_h[rd_idx[1] - 1] !== 1'b0) begin errors++; $display("FAIL b2b_idle_between got busy=%b exp 0", busy_h[rd_idx[1] - 1]); end
    end
  endtask

  task automatic test_blocked();
    int rd = 0, txd_bad = 0, bz = 0;
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) rd++;
      if (txd !== 1'b1) txd_bad++;
      if (busy !== 1'b0) bz++;
    end
    checks++; if (rd != 0) begin errors++; $display("FAIL empty_rd got %0d cycles exp 0", rd); end
    checks++; if (txd_bad != 0) begin errors++; $display("FAIL empty_txd got %0d low cycles exp 0", txd_bad); end
    checks++; if (bz != 0) begin errors++; $display("FAIL empty_busy got %0d cycles exp 0", bz); end
    en = 1'b0;
    push_byte(8'hA5);
    rd = 0; txd_bad = 0; bz = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0) rd++;
      if (txd !== 1'b1) txd_bad++;
      if (busy !== 1'b0) bz++;
    end
    checks++; if (rd != 0) begin errors++; $display("FAIL en_low_rd got %0d cycles exp 0", rd); end
    checks++; if (txd_bad != 0) begin errors++; $display("FAIL en_low_txd got %0d low cycles exp 0", txd_bad); end
    checks++; if (bz != 0) begin errors++; $display("FAIL en_low_busy got %0d cycles exp 0", bz); end
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    int rd, dn, bz;
    en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_start_seen got 0 exp 1"); end
    repeat (N + 6) @(negedge clk);
    @(posedge clk);
    #2;
    res = 1'b0;
    en = 1'b0;
    #1;
    exp_frames = 0;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd got %b exp 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL rst_mid_frames got %h exp 0000", frames_sent); end
    repeat (3) @(negedge clk);
    res = 1'b1;
    push_byte(8'h5A);
    repeat (2) @(negedge clk);
    en = 1'b1;
    run_cycles(60, rd, dn, bz);
    en = 1'b0;
    exp_frames++;
    checks++; if (rd != 1) begin errors++; $display("FAIL rst_after_rd got %0d exp 1", rd); end
    checks++; if (dn != 1) begin errors++; $display("FAIL rst_after_done got %0d exp 1", dn); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL rst_after_frames got %0d exp %0d", frames_sent, exp_frames); end
  endtask

  task automatic test_wrap_en_drop();
    bit found = 1'b0;
    int rd0 = 0, rd, dn, bz;
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    push_byte(8'h81);
    push_byte(8'h42);
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) rd0++;
      if (txd === 1'b0) found = 1'b1;
    end
    en = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL wrap_start_seen got 0 exp 1"); end
    run_cycles(80, rd, dn, bz);
    exp_frames = 0;
    checks++; if (rd0 + rd != 1) begin errors++; $display("FAIL en_drop_rd got %0d exp 1", rd0 + rd); end
    checks++; if (dn != 1) begin errors++; $display("FAIL en_drop_done got %0d exp 1", dn); end
    checks++; if (frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_frames got %h exp 0000", frames_sent); end
  endtask

  task automatic test_drain();
    int rd, dn, bz;
    repeat (2) @(negedge clk);
    en = 1'b1;
    run_cycles(60, rd, dn, bz);
    en = 1'b0;
    exp_frames++;
    checks++; if (rd != 1) begin errors++; $display("FAIL drain_rd got %0d exp 1", rd); end
    checks++; if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL drain_frames got %0d exp %0d", frames_sent, exp_frames); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL drain_scoreboard got %0d left exp 0", sb_q.size()); end
    checks++; if (fifo_q.size() != 0) begin errors++; $display("FAIL drain_fifo got %0d left exp 0", fifo_q.size()); end
    checks++; if (bad_rd !== 1'b0) begin errors++; $display("FAIL read_while_empty got %b exp 0", bad_rd); end
  endtask

  initial begin
    res = 1'b0;
    en = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single(8'hA5, "a5");
    test_single(8'h07, "x07");
    test_back_to_back();
    test_blocked();
    test_reset_mid_frame();
    test_wrap_en_drop();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO and sends each byte as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO: it drives the FIFO read strobe, captures the FIFO's registered data output, and serialises it LSB-first with start and stop bits. It also provides a status/handshake surface (busy, done pulse, frame counter) for the controller.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535; baud counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- res  input  1  reset, asynchronous, active-low.
- en  input  1  transmit enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data (valid the cycle after the edge that samples fifo_rd).
- fifo_rd  output  1  FIFO read strobe; one-cycle pulse per frame.
- txd  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse in the last cycle of STOP.
- frames_sent  output  16  count of completed frames; wraps 0xFFFF -> 0x0000.

## Operation
- Reset (res low, asynchronous): state IDLE, txd=1, fifo_rd=0, busy=0, tx_done=0, frames_sent=0, baud counter=0, bit index=0, shift register=0x00.
- FSM states: IDLE, RD, WAIT, START, DATA, PARITY (only with macro), STOP.
- IDLE: if en=1 and fifo_empty=0 -> RD; else stay. fifo_empty is ignored in all other states.
- RD: one cycle, fifo_rd=1 (Moore output) -> WAIT.
- WAIT: one cycle; at its closing edge, load shift register from fifo_data -> START.
- START: txd=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; txd=shift[0]; shift right at each bit boundary -> PARITY (macro) or STOP.
- PARITY: txd = XOR of the 8 data bits (even parity), CLKS_PER_BIT cycles -> STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles; tx_done=1 in its last cycle; frames_sent += 1 at the closing edge -> IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change.
- Dropping en mid-frame has no effect; the frame completes. en=0 only blocks the next IDLE->RD transition.
- The block never asserts fifo_rd while fifo_empty=1 is sampled in IDLE; no read is issued outside RD.
- txd is registered (glitch-free); it is 1 in IDLE, RD, WAIT.

## Timing
- With fifo_rd high in cycle t: WAIT at t+1, START (txd falls) at t+2, DATA t+2+N .. t+9N+1, STOP follows, where N=CLKS_PER_BIT.
- Frame length on the line: 10N cycles (11N with parity).
- Back-to-back bytes with en=1 and FIFO non-empty: fifo_rd period = 10N+3 cycles (11N+3 with parity); 3 idle-high cycles (IDLE, RD, WAIT) beyond the stop bit.
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronous), frame aborted, frames_sent cleared; the byte already read from the FIFO is lost.
- Reset release: first possible fifo_rd in the second cycle after the first edge with res high.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in, even-parity bit between data and stop; frame 11N cycles.
- Undefined: no PARITY state, DATA -> STOP directly; frame 10N cycles.

## Test plan
- N=4, FIFO holds 0xA5, en=1 -> one fifo_rd pulse; txd = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); tx_done once; frames_sent=1.
- Same with UART_TX_PARITY_EN -> parity bit 0 after data (0xA5 has four ones); 0x07 -> parity bit 1; frame 44 cycles.
- N=4, FIFO holds 0x3C, 0xFF, en=1 -> fifo_rd pulses exactly 43 cycles apart; frames_sent=2; txd high for 3 extra cycles between frames.
- fifo_empty=1 with en=1 for 100 cycles -> fifo_rd never asserts, txd=1, busy=0; en=0 with non-empty FIFO -> same.
- Reset pulse in DATA of 0xA5 -> txd=1, busy=0, frames_sent=0 in the same cycle; after release with FIFO non-empty, next frame starts cleanly from RD.
- Force frames_sent to 0xFFFF, send one byte -> frames_sent=0x0000; en dropped during START -> frame completes, no further fifo_rd.
